branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences the 2-bit branch predictor FSM across the pipeline. Tracks in-flight predicted
//  branches from IF to EX in order, and checks each EX resolution against its prediction.
//  Generates the predictor update strobes (is_Branch / predictor_update / prediction_incorrect),
//  plus the IF redirect and pipeline flush on a mispredict. Sits between IF, EX and branch_predictor.
// PARAMETERS
//  DEPTH      4   in-flight branch entries (power of 2, >=2)
//  PC_W       32  PC width
//  FLUSH_CYC  2   cycles in RECOVER after a mispredict (>=1)
// PORTS
//  clk                   in   1     clock, all state on posedge
//  rst                   in   1     synchronous, active-high reset
//  if_br_valid           in   1     IF fetched a branch this cycle (push request)
//  if_pred_taken         in   1     predictor output sampled for that branch
//  if_alt_pc             in   PC_W  PC of the path NOT predicted (recovery target)
//  ex_br_valid           in   1     EX resolved the oldest in-flight branch
//  ex_taken              in   1     actual outcome
//  if_stall              out  1     FIFO full: IF must hold the branch
//  redirect_valid        out  1     one-cycle pulse: load redirect_pc into PC
//  redirect_pc           out  PC_W  recovery target
//  flush                 out  1     squash IF/ID/EX younger ops; high whole RECOVER
//  is_Branch             out  1     to predictor
//  predictor_update      out  1     to predictor, one-cycle pulse per resolution
//  prediction_incorrect  out  1     to predictor, qualified by predictor_update
//  resolve_err           out  1     sticky: resolution seen with FIFO empty
// BEHAVIOUR
//  Reset: FIFO empty, wr/rd ptr=0, count=0, state=RUN.
//   All outputs are 0 and redirect_pc=0, except if_stall, which is combinational (0 when empty).
//  FIFO entry={pred_taken, alt_pc}; ptrs $clog2(DEPTH) bits wrap mod DEPTH; count 0..DEPTH.
//  if_stall = (count==DEPTH) || state==RECOVER (comb).
//  Push accepted when if_br_valid && !if_stall && !mispredict_now; the entry is written at the edge.
//  Resolution (state==RUN, ex_br_valid, count>0):
//   - The head entry is popped at the edge. mispredict_now = ex_taken != head.pred_taken (comb).
//   - Next cycle: predictor_update=1, is_Branch=1, prediction_incorrect=mispredict_now (registered,
//     so the predictor sees a one-cycle-late strobe and never a combinational loop).
//   - If correct: no flush. Push and pop in the same cycle are both applied and count is unchanged.
//   - If mispredict:
//     - Registered next cycle: redirect_valid=1, redirect_pc=head.alt_pc.
//     - The FIFO is cleared (ptrs=0, count=0), because younger entries are wrong-path.
//     - A same-cycle push is dropped.
//     - state->RECOVER.
//  RECOVER:
//   - flush=1 for FLUSH_CYC cycles; the downcounter is loaded with FLUSH_CYC-1 on entry.
//   - Pushes are ignored (if_stall=1). ex_br_valid is ignored, because it is a wrong-path op.
//   - At counter==0 -> RUN.
//   - redirect_valid is high only in the first RECOVER cycle.
//  Resolution with count==0 in RUN:
//   - No pop and no update pulse.
//   - resolve_err set, and cleared only by rst.
//  Push when full: not accepted (if_stall), so state is unchanged; IF must re-present.
//  Full + correct resolution in same cycle: the push is still refused, because if_stall is
//   evaluated on the current count (no bypass).
//  rst mid-RECOVER or mid-update: everything returns to the reset values on the next edge.
//   Any pending update pulse is lost.
//  State enc one-hot, 2 bits: RUN=2'b01, RECOVER=2'b10; illegal -> RUN with FIFO cleared.
// STRUCTURE
//  Shared define.v: RUN/RECOVER state codes and the FIFO entry field offsets (PRED bit = PC_W).
//  One sub-module: br_inflight_fifo.
//   - Params DEPTH, W=PC_W+1. Ports clk, rst, push, pop, clear, din, dout(head), count, full, empty.
//   - clear has priority over push/pop.
//  Top: FSM, recover counter, registered update/redirect stage, resolve_err.
// TESTING
//  1 Reset: after rst, all outputs 0, if_stall=0; 3 idle cycles -> no predictor_update.
//  2 Correct path: push (pred=1, alt=0x100) then resolve ex_taken=1
//    -> next cycle predictor_update=1, prediction_incorrect=0, flush=0, count=0.
//  3 Mispredict: push A (pred=1, alt=0x200) and B, resolve A with ex_taken=0
//    -> redirect_valid 1 cycle with pc=0x200.
//    -> flush high 2 cycles, prediction_incorrect=1, B discarded, the next resolve gives resolve_err=0.
//  4 Full: 4 pushes -> if_stall=1. A 5th push is held. A correct resolve frees an entry and the
//    5th push is accepted the following cycle.
//  5 Simultaneous: count=2, mispredict resolve + push the same cycle -> count=0 after the edge,
//    and the push is dropped.
//  6 Error/reset: ex_br_valid with empty FIFO -> resolve_err=1, no update.
//    Assert rst during RECOVER -> flush=0, resolve_err=0 next cycle.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for branch resolution control:
// FSM state codes and in-flight entry layout.
package branch_resolve_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b01,
    RECOVER = 2'b10
  } br_state_e;

  localparam int ALT_LSB = 0;

  function automatic int pred_bit(input int pc_w);
    return pc_w;
  endfunction

endpackage

// File: rtl/br_inflight_fifo.sv
// In-order FIFO of predicted branches between IF and EX.
// Clear wins over push/pop to drop wrong-path entries.
module br_inflight_fifo
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == NW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks predicted branches IF->EX, checks EX outcome,
// strobes predictor updates and recovers on mispredict.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_br_valid,
  input  logic            if_pred_taken,
  input  logic [PC_W-1:0] if_alt_pc,
  input  logic            ex_br_valid,
  input  logic            ex_taken,
  output logic            if_stall,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            is_Branch,
  output logic            predictor_update,
  output logic            prediction_incorrect,
  output logic            resolve_err
);

  localparam int W  = PC_W + 1;
  localparam int CW = $clog2(FLUSH_CYC + 1);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int PB = pred_bit(PC_W);

  br_state_e       state;
  br_state_e       state_nxt;
  logic [CW-1:0]   rcnt;
  logic [CW-1:0]   rcnt_nxt;
  logic [W-1:0]    head;
  logic [W-1:0]    din;
  logic [NW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            clear;
  logic            illegal;
  logic            resolve;
  logic            mispredict_now;
  logic            upd_q;
  logic            inc_q;
  logic            redir_q;
  logic            err_q;
  logic [PC_W-1:0] redir_pc_q;

  assign if_stall       = (count == NW'(DEPTH)) || (state == RECOVER);
  assign resolve        = (state == RUN) && ex_br_valid && !empty;
  assign mispredict_now = resolve && (ex_taken != head[PB]);
  assign push           = if_br_valid && !if_stall && !full && !mispredict_now;
  assign pop            = resolve;
  assign clear          = mispredict_now || illegal;
  assign din            = {if_pred_taken, if_alt_pc};

  br_inflight_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (din),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    illegal   = 1'b0;
    case (state)
      RUN: begin
        if (mispredict_now) begin
          state_nxt = RECOVER;
          rcnt_nxt  = CW'(FLUSH_CYC - 1);
        end
      end
      RECOVER: begin
        if (rcnt == '0) state_nxt = RUN;
        else            rcnt_nxt  = rcnt - CW'(1);
      end
      default: begin
        state_nxt = RUN;
        illegal   = 1'b1;
      end
    endcase
  end

  // Update strobes are registered so the predictor never sees a comb loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_q      <= 1'b0;
      inc_q      <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      upd_q   <= resolve;
      inc_q   <= mispredict_now;
      redir_q <= mispredict_now;
      if (mispredict_now) redir_pc_q <= head[PC_W-1:ALT_LSB];
      if ((state == RUN) && ex_br_valid && empty) err_q <= 1'b1;
    end
  end

  assign flush                = (state == RECOVER);
  assign redirect_valid       = redir_q;
  assign redirect_pc          = redir_pc_q;
  assign is_Branch            = upd_q;
  assign predictor_update     = upd_q;
  assign prediction_incorrect = inc_q;
  assign resolve_err          = err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_br_valid = 1'b0;
  logic        if_pred_taken = 1'b0;
  logic [31:0] if_alt_pc = '0;
  logic        ex_br_valid = 1'b0;
  logic        ex_taken = 1'b0;
  logic        if_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        is_Branch;
  logic        predictor_update;
  logic        prediction_incorrect;
  logic        resolve_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .if_br_valid          (if_br_valid),
    .if_pred_taken        (if_pred_taken),
    .if_alt_pc            (if_alt_pc),
    .ex_br_valid          (ex_br_valid),
    .ex_taken             (ex_taken),
    .if_stall             (if_stall),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .flush                (flush),
    .is_Branch            (is_Branch),
    .predictor_update     (predictor_update),
    .prediction_incorrect (prediction_incorrect),
    .resolve_err          (resolve_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_br_valid = 1'b0;
    ex_br_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_br(input logic pred, input logic [31:0] alt);
    if_br_valid   = 1'b1;
    if_pred_taken = pred;
    if_alt_pc     = alt;
    tick();
    if_br_valid   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({redirect_valid, flush, is_Branch, predictor_update,
         prediction_incorrect, resolve_err, if_stall} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outs got %b want 0", {redirect_valid, flush,
        is_Branch, predictor_update, prediction_incorrect, resolve_err, if_stall});
    end
    tests++;
    if (redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_pc got %h want 0", redirect_pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (predictor_update !== 1'b0) begin
        fails++;
        $display("FAIL idle_upd%0d got %b want 0", i, predictor_update);
      end
    end
  endtask

  task automatic test_correct();
    do_reset();
    push_br(1'b1, 32'h100);
    tests++;
    if (dut.u_fifo.count !== 3'd1) begin
      fails++;
      $display("FAIL corr_cnt1 got %0d want 1", dut.u_fifo.count);
    end
    ex_br_valid = 1'b1;
    ex_taken    = 1'b1;
    tick();
    idle();
    tests++;
    if ({predictor_update, is_Branch, prediction_incorrect, flush, redirect_valid}
        !== 5'b11000) begin
      fails++;
      $display("FAIL corr_strobe got %b want 11000", {predictor_update,
        is_Branch, prediction_incorrect, flush, redirect_valid});
    end
    tests++;
    if (dut.u_fifo.count !== 3'd0) begin
      fails++;
      $display("FAIL corr_cnt0 got %0d want 0", dut.u_fifo.count);
    end
    tick();
    tests++;
    if (predictor_update !== 1'b0) begin
      fails++;
      $display("FAIL corr_pulse got %b want 0", predictor_update);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    push_br(1'b1, 32'h200);
    push_br(1'b0, 32'h300);
    tests++;
    if (dut.u_fifo.count !== 3'd2) begin
      fails++;
      $display("FAIL misp_cnt2 got %0d want 2", dut.u_fifo.count);
    end
    ex_br_valid = 1'b1;
    ex_taken    = 1'b0;
    tick();
    idle();
    tests++;
    if ({redirect_valid, flush, predictor_update, prediction_incorrect, if_stall}
        !== 5'b11111) begin
      fails++;
      $display("FAIL misp_c1 got %b want 11111", {redirect_valid, flush,
        predictor_update, prediction_incorrect, if_stall});
    end
    tests++;
    if (redirect_pc !== 32'h200) begin
      fails++;
      $display("FAIL misp_pc got %h want 200", redirect_pc);
    end
    tests++;
    if (dut.u_fifo.count !== 3'd0) begin
      fails++;
      $display("FAIL misp_cnt0 got %0d want 0", dut.u_fifo.count);
    end
    ex_br_valid = 1'b1;
    ex_taken    = 1'b1;
    if_br_valid = 1'b1;
    tick();
    idle();
    tests++;
    if ({redirect_valid, flush, predictor_update} !== 3'b010) begin
      fails++;
      $display("FAIL misp_c2 got %b want 010",
        {redirect_valid, flush, predictor_update});
    end
    tests++;
    if (dut.u_fifo.count !== 3'd0) begin
      fails++;
      $display("FAIL misp_ign got %0d want 0", dut.u_fifo.count);
    end
    tick();
    tests++;
    if ({flush, if_stall, resolve_err, predictor_update} !== 4'b0000) begin
      fails++;
      $display("FAIL misp_end got %b want 0000",
        {flush, if_stall, resolve_err, predictor_update});
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) push_br(1'b0, 32'h400 + 32'(i * 4));
    tests++;
    if (if_stall !== 1'b1 || dut.u_fifo.count !== 3'd4) begin
      fails++;
      $display("FAIL full_stall got %b/%0d want 1/4", if_stall, dut.u_fifo.count);
    end
    if_br_valid   = 1'b1;
    if_pred_taken = 1'b1;
    if_alt_pc     = 32'h4F0;
    tick();
    tests++;
    if (dut.u_fifo.count !== 3'd4 || if_stall !== 1'b1) begin
      fails++;
      $display("FAIL full_hold got %0d/%b want 4/1", dut.u_fifo.count, if_stall);
    end
    ex_br_valid = 1'b1;
    ex_taken    = 1'b0;
    tick();
    ex_br_valid = 1'b0;
    tests++;
    if (dut.u_fifo.count !== 3'd3 || if_stall !== 1'b0) begin
      fails++;
      $display("FAIL full_pop got %0d/%b want 3/0", dut.u_fifo.count, if_stall);
    end
    tests++;
    if (predictor_update !== 1'b1 || prediction_incorrect !== 1'b0) begin
      fails++;
      $display("FAIL full_upd got %b%b want 10",
        predictor_update, prediction_incorrect);
    end
    tick();
    idle();
    tests++;
    if (dut.u_fifo.count !== 3'd4 || if_stall !== 1'b1) begin
      fails++;
      $display("FAIL full_push5 got %0d/%b want 4/1", dut.u_fifo.count, if_stall);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_br(1'b1, 32'h500);
    push_br(1'b0, 32'h600);
    ex_br_valid   = 1'b1;
    ex_taken      = 1'b0;
    if_br_valid   = 1'b1;
    if_pred_taken = 1'b0;
    if_alt_pc     = 32'h700;
    tick();
    idle();
    tests++;
    if (dut.u_fifo.count !== 3'd0) begin
      fails++;
      $display("FAIL simul_cnt got %0d want 0", dut.u_fifo.count);
    end
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h500) begin
      fails++;
      $display("FAIL simul_redir got %b/%h want 1/500", redirect_valid, redirect_pc);
    end
    tick();
    tick();
    tests++;
    if (dut.u_fifo.count !== 3'd0 || flush !== 1'b0) begin
      fails++;
      $display("FAIL simul_end got %0d/%b want 0/0", dut.u_fifo.count, flush);
    end
  endtask

  task automatic test_err_reset();
    do_reset();
    ex_br_valid = 1'b1;
    ex_taken    = 1'b1;
    tick();
    idle();
    tests++;
    if (resolve_err !== 1'b1 || predictor_update !== 1'b0) begin
      fails++;
      $display("FAIL err_set got %b/%b want 1/0", resolve_err, predictor_update);
    end
    tick();
    tests++;
    if (resolve_err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky got %b want 1", resolve_err);
    end
    push_br(1'b1, 32'h800);
    ex_br_valid = 1'b1;
    ex_taken    = 1'b0;
    tick();
    idle();
    tests++;
    if (flush !== 1'b1) begin
      fails++;
      $display("FAIL err_recover got %b want 1", flush);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({flush, resolve_err, predictor_update, redirect_valid, if_stall}
        !== 5'b00000) begin
      fails++;
      $display("FAIL err_rst got %b want 00000", {flush, resolve_err,
        predictor_update, redirect_valid, if_stall});
    end
    tests++;
    if (redirect_pc !== 32'h0) begin
      fails++;
      $display("FAIL err_rst_pc got %h want 0", redirect_pc);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_back_to_back();
    test_err_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
